intg_recover: RTL and testbench
===============================

# intg_recover

Inverse of the windowed ×25 integrator. Accepts the integrator's running-sum samples, differences consecutive sums, and divides each difference by 25 with a 4-cycle restoring divider to recover the original 4-bit input sample. Window framing matches the integrator: the running sum restarts from 0 every WIN samples. Sits at the receive end of the integrator link and hands recovered samples downstream over a valid/ready handshake.

## Interface

- WIN, 4, samples per accumulation window (≥2); the difference base returns to 0 after the WIN-th sample
- K, 25, integrator gain (divisor); fixed at 25 for this revision
- CLK  in  1  clock, rising-edge
- acc_rst2  in  1  reset, asynchronous, active-high
- y_in  in  13  running sum from the integrator
- y_valid  in  1  y_in valid
- y_ready  out  1  block can accept y_in; high exactly in IDLE
- x_out  out  4  recovered sample
- x_valid  out  1  x_out valid; high exactly in OUT
- x_ready  in  1  downstream accepts x_out
- x_last  out  1  high with x_valid for the WIN-th sample of a window
- err  out  1  sticky error flag (see Configuration)

## Operation

- Registers: prev[12:0], rem[8:0], q[3:0], cnt (width clog2(WIN)), step[1:0], state ∈ {IDLE, DIV, OUT}, err.
- IDLE: y_ready=1. On y_valid&&y_ready:
  - diff = (y_in − prev) mod 2^13.
  - ovf = (diff ≥ 400).
  - rem ← diff[8:0]; q ← 0; step ← 3; state → DIV.
  - If cnt==WIN−1: prev ← 0, cnt ← 0, set the last flag. Otherwise prev ← y_in, cnt ← cnt+1.
- DIV, one iteration per cycle for i=3,2,1,0:
  - If rem ≥ 25·2^i: rem ← rem − 25·2^i and q[i] ← 1.
  - After i=0, state → OUT.
- OUT: x_out = ovf ? 15 : q. x_valid=1. x_last=last flag. On x_ready: state → IDLE and x_valid drops.
- A negative difference wraps to a large value. It is treated as overflow: x_out=15.
- While y_ready=0, y_in and y_valid are ignored. There is no skid buffer.

## Timing

- Reset values: x_out=0, x_valid=0, x_last=0, err=0, y_ready=1, prev=0, cnt=0, state=IDLE.
- Acceptance at edge k puts the block in DIV after k. Iterations happen at edges k+1..k+4, and x_valid is high after edge k+4. Latency is 4 cycles.
- Handoff at edge k+5 at the earliest. y_ready is high after k+5, so the next accept can happen at k+6. Peak throughput is 1 sample per 6 cycles.
- Backpressure: x_out, x_valid and x_last are held stable while x_ready=0. y_ready stays 0.
- acc_rst2 mid-DIV or mid-OUT: the sample is abandoned with no x_valid. The window restarts at cnt=0 with prev=0. err clears.
- x_ready high outside OUT has no effect.

## Configuration

- INTG_RECOVER_CHECK_EN defined:
  - err is set on any accepted sample with ovf=1, or with remainder ≠ 0 after the final DIV step. The remainder check is evaluated at the DIV→OUT transition.
  - err stays set until acc_rst2.
- Not defined:
  - err is tied to 0 and the remainder comparison is not built.
  - x_out saturation to 15 on ovf remains.

## Test plan

- Clean window, WIN=4, x_ready=1: feed y = 250, 375, 675, 700. Required x_out = 10, 5, 12, 1; x_last only on 1; err=0.
- Window restart: continue with y = 325, 500, 725, 775. Required x_out = 13, 7, 9, 2. This confirms prev restarted at 0.
- Latency and backpressure:
  - Accept a sample at edge k; x_valid must be high after edge k+4.
  - Hold x_ready=0 for 3 cycles; x_out and x_valid stay stable and y_ready=0.
  - Raise x_ready; y_ready rises the following cycle.
- Error path with CHECK_EN, from prev=0:
  - y=260 → x_out=10, err=1.
  - After acc_rst2, y=500 → x_out=15, err=1.
  - Without CHECK_EN, both cases give err=0 and the same x_out.
- Wrap: prev=700, next y=100. The difference wraps, so x_out=15 and (with CHECK_EN) err=1.
- Reset mid-operation: assert acc_rst2 two cycles after an accept. x_valid never rises. Then y=125 → x_out=5 with cnt restarted, so x_last appears on the 4th subsequent sample.

Source files
------------

// File: rtl/intg_recover_if.sv
// Handshake bundle between the integrator link receiver and its downstream consumer.
// The master modport is the side that drives samples in and accepts recovered samples.
interface intg_recover_if;
    logic [12:0] y_in;
    logic        y_valid;
    logic        y_ready;
    logic [3:0]  x_out;
    logic        x_valid;
    logic        x_ready;
    logic        x_last;
    logic        err;

    modport master (
        output y_in, y_valid, x_ready,
        input  y_ready, x_out, x_valid, x_last, err
    );

    modport slave (
        input  y_in, y_valid, x_ready,
        output y_ready, x_out, x_valid, x_last, err
    );
endinterface

// File: rtl/intg_recover.sv
// Inverse of the windowed x25 integrator: differences running sums and divides by K
// with a 4-step restoring divider. Optional checking enabled by INTG_RECOVER_CHECK_EN.
module intg_recover #(
    parameter int WIN = 4,
    parameter int K   = 25
) (
    input  logic         CLK,
    input  logic         acc_rst2,
    intg_recover_if.slave bus
);

    localparam int CNT_W   = (WIN > 2) ? $clog2(WIN) : 1;
    localparam int OVF_LIM = 16 * K;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t            state_reg;
    logic [12:0]       prev_reg;
    logic [8:0]        rem_reg;
    logic [3:0]        q_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [1:0]        step_reg;
    logic              ovf_reg;
    logic              last_reg;
    logic [3:0]        x_out_reg;
    logic              x_valid_reg;
    logic              x_last_reg;
    logic              y_ready_reg;
`ifdef INTG_RECOVER_CHECK_EN
    logic              err_reg;
`endif

    // Shifted divisor table K*2^i, indexed by the current divider step.
    logic [8:0] div_const [4];
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_div_const
            assign div_const[gi] = 9'(K << gi);
        end
    endgenerate

    logic [12:0] diff;
    logic        ovf_now;
    logic        last_now;
    logic        trial_ge;
    logic [8:0]  rem_next;
    logic [3:0]  q_next;

    // Negative differences wrap to large values and land in the overflow range.
    assign diff     = bus.y_in - prev_reg;
    assign ovf_now  = (diff >= 13'(OVF_LIM));
    assign last_now = (cnt_reg == CNT_W'(WIN - 1));
    assign trial_ge = (rem_reg >= div_const[step_reg]);
    assign rem_next = trial_ge ? (rem_reg - div_const[step_reg]) : rem_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_q_next
            assign q_next[gi] = q_reg[gi] | (trial_ge && (step_reg == 2'(gi)));
        end
    endgenerate

    always_ff @(posedge CLK or posedge acc_rst2) begin
        if (acc_rst2) begin
            state_reg   <= IDLE;
            prev_reg    <= '0;
            rem_reg     <= '0;
            q_reg       <= '0;
            cnt_reg     <= '0;
            step_reg    <= '0;
            ovf_reg     <= 1'b0;
            last_reg    <= 1'b0;
            x_out_reg   <= '0;
            x_valid_reg <= 1'b0;
            x_last_reg  <= 1'b0;
            y_ready_reg <= 1'b1;
`ifdef INTG_RECOVER_CHECK_EN
            err_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.y_valid) begin
                        rem_reg     <= diff[8:0];
                        q_reg       <= '0;
                        step_reg    <= 2'd3;
                        ovf_reg     <= ovf_now;
                        last_reg    <= last_now;
                        y_ready_reg <= 1'b0;
                        state_reg   <= DIV;
                        // The window's difference base returns to zero after its last sample.
                        if (last_now) begin
                            prev_reg <= '0;
                            cnt_reg  <= '0;
                        end else begin
                            prev_reg <= bus.y_in;
                            cnt_reg  <= cnt_reg + CNT_W'(1);
                        end
`ifdef INTG_RECOVER_CHECK_EN
                        if (ovf_now)
                            err_reg <= 1'b1;
`endif
                    end
                end
                DIV: begin
                    rem_reg <= rem_next;
                    q_reg   <= q_next;
                    if (step_reg == 2'd0) begin
                        state_reg   <= OUT;
                        x_valid_reg <= 1'b1;
                        x_last_reg  <= last_reg;
                        x_out_reg   <= ovf_reg ? 4'd15 : q_next;
`ifdef INTG_RECOVER_CHECK_EN
                        if (rem_next != 9'd0)
                            err_reg <= 1'b1;
`endif
                    end else begin
                        step_reg <= step_reg - 2'd1;
                    end
                end
                OUT: begin
                    if (bus.x_ready) begin
                        state_reg   <= IDLE;
                        x_valid_reg <= 1'b0;
                        x_last_reg  <= 1'b0;
                        y_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    x_valid_reg <= 1'b0;
                    x_last_reg  <= 1'b0;
                    y_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.y_ready = y_ready_reg;
    assign bus.x_out   = x_out_reg;
    assign bus.x_valid = x_valid_reg;
    assign bus.x_last  = x_last_reg;
`ifdef INTG_RECOVER_CHECK_EN
    assign bus.err     = err_reg;
`else
    assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_intg_recover.sv
// Directed and randomized checks of intg_recover against an arithmetic reference model.
module tb_intg_recover;

    localparam int WIN = 4;
`ifdef INTG_RECOVER_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic CLK;
    logic acc_rst2;

    intg_recover_if bus ();

    intg_recover #(.WIN(WIN), .K(25)) dut (
        .CLK      (CLK),
        .acc_rst2 (acc_rst2),
        .bus      (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: sample count since reset, last sum, sticky error.
    logic [12:0] m_prev;
    int          m_idx;
    bit          m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = '0;
        m_idx  = 0;
        m_err  = 1'b0;
    endtask

    task automatic model_step(input logic [12:0] y, output int ex, output bit el);
        logic [12:0] d;
        d  = y - m_prev;
        ex = (d >= 13'd400) ? 15 : int'(d) / 25;
        el = ((m_idx % WIN) == WIN - 1);
        if (CHECK_EN && ((d >= 13'd400) || (int'(d) % 25 != 0)))
            m_err = 1'b1;
        m_prev = el ? 13'd0 : y;
        m_idx++;
    endtask

    // Called #1 after a rising edge; leaves the bench #1 after a rising edge.
    task automatic apply_reset();
        acc_rst2 = 1'b1;
        #1;
        check("rst.x_valid", bus.x_valid, 0);
        check("rst.x_out",   bus.x_out,   0);
        check("rst.x_last",  bus.x_last,  0);
        check("rst.err",     bus.err,     0);
        check("rst.y_ready", bus.y_ready, 1);
        @(posedge CLK); #1;
        acc_rst2 = 1'b0;
        model_reset();
    endtask

    task automatic feed(input logic [12:0] y, input int hold, input string tag);
        int         ex;
        bit         el;
        int         lat;
        logic [3:0] held;
        check({tag, ".y_ready_pre"}, bus.y_ready, 1);
        model_step(y, ex, el);
        bus.y_in    = y;
        bus.y_valid = 1'b1;
        bus.x_ready = (hold == 0);
        @(posedge CLK); #1;
        bus.y_valid = 1'b0;
        bus.y_in    = 13'($urandom);
        check({tag, ".y_ready_busy"}, bus.y_ready, 0);
        lat = 0;
        while (bus.x_valid !== 1'b1 && lat < 12) begin
            @(posedge CLK); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, 4);
        check({tag, ".x_out"},  bus.x_out,  ex);
        check({tag, ".x_last"}, bus.x_last, el);
        check({tag, ".err"},    bus.err,    m_err);
        held = bus.x_out;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            check({tag, ".hold_x_out"},   bus.x_out,   held);
            check({tag, ".hold_x_valid"}, bus.x_valid, 1);
            check({tag, ".hold_y_ready"}, bus.y_ready, 0);
        end
        bus.x_ready = 1'b1;
        @(posedge CLK); #1;
        bus.x_ready = 1'b0;
        check({tag, ".x_valid_drop"}, bus.x_valid, 0);
        check({tag, ".y_ready_back"}, bus.y_ready, 1);
        $display("txn %s y=%0d x_out=%0d exp=%0d last=%0d err=%0d", tag, y, held, ex, el, bus.err);
    endtask

    initial begin
        logic [12:0] ry;
        int          r;
        acc_rst2    = 1'b1;
        bus.y_in    = '0;
        bus.y_valid = 1'b0;
        bus.x_ready = 1'b0;
        model_reset();
        @(posedge CLK); #1;
        apply_reset();

        // Clean window, then a second window confirming the base restart.
        feed(13'd250, 0, "w1s0");
        feed(13'd375, 0, "w1s1");
        feed(13'd675, 0, "w1s2");
        feed(13'd700, 0, "w1s3");
        feed(13'd325, 0, "w2s0");
        feed(13'd500, 0, "w2s1");
        feed(13'd725, 0, "w2s2");
        feed(13'd775, 0, "w2s3");

        // Backpressure for three cycles.
        feed(13'd25, 3, "bp");

        // Remainder error, then overflow error after a reset.
        @(posedge CLK); #1;
        apply_reset();
        feed(13'd260, 0, "rem_err");
        apply_reset();
        feed(13'd500, 1, "ovf_err");

        // Negative difference wraps into overflow.
        apply_reset();
        feed(13'd375, 0, "wrap0");
        feed(13'd700, 0, "wrap1");
        feed(13'd100, 2, "wrap2");

        // Reset two cycles after an accept abandons the sample.
        apply_reset();
        bus.y_in    = 13'd300;
        bus.y_valid = 1'b1;
        @(posedge CLK); #1;
        bus.y_valid = 1'b0;
        @(posedge CLK); #1;
        acc_rst2 = 1'b1;
        #1;
        check("midrst.x_valid_in_rst", bus.x_valid, 0);
        @(posedge CLK); #1;
        acc_rst2 = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            check("midrst.x_valid_quiet", bus.x_valid, 0);
        end
        feed(13'd125, 0, "midrst0");
        feed(13'd200, 0, "midrst1");
        feed(13'd450, 1, "midrst2");
        feed(13'd475, 0, "midrst3");

        // Randomized traffic, mostly clean multiples with some off-grid and arbitrary sums.
        apply_reset();
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            if (r < 6)
                ry = m_prev + 13'(25 * $urandom_range(0, 15));
            else if (r < 8)
                ry = m_prev + 13'($urandom_range(0, 420));
            else
                ry = 13'($urandom);
            feed(ry, $urandom_range(0, 2), $sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
